// File: rtl/usart_rx.sv
// UART receiver: 8N1 deserialiser feeding a first-word-fall-through circular FIFO.
// Define USART_RX_PARITY_EN for 8E1 frames with a parity_err pulse output.
module usart_rx #(
  parameter int unsigned CLOCKS_PER_BIT  = 868,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     frame_err,
  output logic                     overrun
`ifdef USART_RX_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned AW    = FIFO_DEPTH_LOG2;
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_CNT   = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [AW:0]      DEPTH_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef USART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BRK    = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic             sync1, rx_s;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             tick_c, push_c, ferr_c, pop_c, push_ok_c, ovr_c;
`ifdef USART_RX_PARITY_EN
  logic             par_bit;
  logic             perr_c;
`endif

  logic [7:0]    mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-cycle frame events
  always_comb begin
    state_nxt = state;
    push_c    = 1'b0;
    ferr_c    = 1'b0;
    tick_c    = (state == S_START) ? (clk_cnt == HALF_CNT) : (clk_cnt == BIT_CNT);
`ifdef USART_RX_PARITY_EN
    perr_c    = 1'b0;
`endif
    case (state)
      S_IDLE:  if (!rx_s) state_nxt = S_START;
      S_START: if (tick_c) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (tick_c && bit_idx == 3'd7) begin
`ifdef USART_RX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
`ifdef USART_RX_PARITY_EN
      S_PARITY: if (tick_c) state_nxt = S_STOP;
`endif
      S_STOP: begin
        if (tick_c) begin
`ifdef USART_RX_PARITY_EN
          perr_c = ^{shift, par_bit};
          push_c = rx_s && !perr_c;
`else
          push_c = rx_s;
`endif
          ferr_c    = !rx_s;
          state_nxt = rx_s ? S_IDLE : S_BRK;
        end
      end
      S_BRK:   if (rx_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pop_c     = rd_en && !empty;
  assign push_ok_c = push_c && (!full || pop_c);
  assign ovr_c     = push_c && full && !pop_c;

  // Synchroniser, bit timing, shift register and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef USART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
      if (state == S_IDLE || state_nxt != state || tick_c) clk_cnt <= '0;
      else                                                 clk_cnt <= clk_cnt + CNT_W'(1);
      if (state != S_DATA) begin
        bit_idx <= '0;
      end else if (tick_c) begin
        shift[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;
      end
      frame_err <= ferr_c;
      overrun   <= ovr_c;
`ifdef USART_RX_PARITY_EN
      if (state == S_PARITY && tick_c) par_bit <= rx_s;
      parity_err <= perr_c;
`endif
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok_c, pop_c})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c && !reset) mem[wr_ptr] <= shift;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);

endmodule
